// File: rtl/shake_pkg.sv
// Shared SHAKE definitions: block geometry, mode codes, packer FSM states and block metadata.
package shake_pkg;
    localparam int SHAKE_BLK_W         = 1024;
    localparam int SHAKE_IN_W          = 64;
    localparam int SHAKE_WORDS_PER_BLK = SHAKE_BLK_W / SHAKE_IN_W;

    localparam logic SHAKE_MODE_128 = 1'b0;
    localparam logic SHAKE_MODE_256 = 1'b1;

    localparam logic [0:0] PK_FILL = 1'b0;
    localparam logic [0:0] PK_SEND = 1'b1;

    typedef struct packed {
        logic [6:0] byte_len;
        logic       last;
    } shake_meta_t;

    // Non-last words are always full; a last word with an out-of-range count degrades to full.
    function automatic logic [3:0] shake_eff_bytes(input logic [3:0] nbytes, input logic last);
        if (last && nbytes != 4'd0 && nbytes <= 4'd8)
            return nbytes;
        return 4'd8;
    endfunction
endpackage

// File: rtl/shake_word_mask.sv
// Byte-enable masking of one message word (optional byte swap under SHAKE_PACK_BSWAP_EN).
// Latency: combinational. Backpressure: none, pure function of its inputs.
module shake_word_mask
    import shake_pkg::*;
(
    input  logic [SHAKE_IN_W-1:0] data,
    input  logic [3:0]            nbytes,
    input  logic                  last,
    output logic [SHAKE_IN_W-1:0] word,
    output logic [3:0]            eff_bytes
);
    logic [SHAKE_IN_W-1:0] ordered;

    always_comb begin
        eff_bytes = shake_eff_bytes(nbytes, last);
        ordered   = data;
`ifdef SHAKE_PACK_BSWAP_EN
        // Big-endian stream: the first message byte arrives in the top byte lane.
        for (int j = 0; j < 8; j++)
            ordered[8*j +: 8] = data[8*(7-j) +: 8];
`endif
        word = '0;
        for (int j = 0; j < 8; j++)
            if (4'(j) < eff_bytes)
                word[8*j +: 8] = ordered[8*j +: 8];
    end
endmodule

// File: rtl/shake_msg_packer.sv
// Packs 64-bit message words little-endian into 1024-bit sponge blocks (SHAKE_PACK_BSWAP_EN: big-endian words).
// Latency: up to 16 fill cycles + 1 present cycle, then held until i_ack.
// Backpressure: s_ready is high only while filling; a presented block stalls the input until acked.
module shake_msg_packer
    import shake_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SHAKE_IN_W-1:0]  s_data,
    input  logic [3:0]             s_bytes,
    input  logic                   s_last,
    input  logic                   s_mode,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [SHAKE_BLK_W-1:0] o_din,
    output logic [6:0]             o_byte_len,
    output logic                   o_last,
    output logic                   o_mode,
    output logic                   o_valid,
    input  logic                   i_ack,
    output logic                   busy
);
    logic [0:0]             state;
    logic [3:0]             wcnt;
    logic [SHAKE_BLK_W-1:0] buffer;
    logic                   pend_empty;
    logic                   first_blk;
    logic                   mode_q;
    logic                   hold_q;
    shake_meta_t            blk_meta;

    logic [SHAKE_IN_W-1:0]  word_m;
    logic [3:0]             eff_bytes;
    logic [7:0]             tot;
    logic                   accept;

    shake_word_mask u_mask (
        .data      (s_data),
        .nbytes    (s_bytes),
        .last      (s_last),
        .word      (word_m),
        .eff_bytes (eff_bytes)
    );

    assign s_ready = (state == PK_FILL);
    assign accept  = s_valid && s_ready;
    assign tot     = {1'b0, wcnt, 3'b000} + {4'b0000, eff_bytes};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= PK_FILL;
            wcnt       <= '0;
            buffer     <= '0;
            pend_empty <= 1'b0;
            first_blk  <= 1'b1;
            mode_q     <= SHAKE_MODE_128;
            hold_q     <= 1'b0;
            blk_meta   <= '0;
            busy       <= 1'b0;
            o_valid    <= 1'b0;
            o_din      <= '0;
            o_byte_len <= '0;
            o_last     <= 1'b0;
            o_mode     <= 1'b0;
        end else begin
            // The sponge samples last one cycle after ack, so it is dropped a cycle late.
            if (hold_q) begin
                hold_q     <= 1'b0;
                o_last     <= 1'b0;
                o_byte_len <= '0;
            end
            case (state)
                PK_FILL: begin
                    if (accept) begin
                        buffer[{wcnt, 6'd0} +: SHAKE_IN_W] <= word_m;
                        wcnt <= wcnt + 4'd1;
                        busy <= 1'b1;
                        if (first_blk && wcnt == 4'd0) begin
                            mode_q    <= s_mode;
                            first_blk <= 1'b0;
                        end
                        if (s_last) begin
                            state <= PK_SEND;
                            if (tot == 8'd128) begin
                                // Exactly full: the terminating block must be a separate empty one.
                                blk_meta   <= '{byte_len: 7'd0, last: 1'b0};
                                pend_empty <= 1'b1;
                            end else begin
                                blk_meta <= '{byte_len: tot[6:0], last: 1'b1};
                            end
                        end else if (wcnt == 4'(SHAKE_WORDS_PER_BLK - 1)) begin
                            state    <= PK_SEND;
                            blk_meta <= '{byte_len: 7'd0, last: 1'b0};
                        end
                    end
                end
                default: begin
                    if (!o_valid) begin
                        o_valid    <= 1'b1;
                        o_din      <= buffer;
                        o_byte_len <= blk_meta.byte_len;
                        o_last     <= blk_meta.last;
                        o_mode     <= mode_q;
                    end else if (i_ack) begin
                        o_valid <= 1'b0;
                        buffer  <= '0;
                        wcnt    <= '0;
                        hold_q  <= 1'b1;
                        if (pend_empty) begin
                            pend_empty <= 1'b0;
                            blk_meta   <= '{byte_len: 7'd0, last: 1'b1};
                        end else begin
                            state <= PK_FILL;
                            if (blk_meta.last) begin
                                busy      <= 1'b0;
                                first_blk <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    bytes_in_range: assert property (@(posedge clk) disable iff (!rst)
        (s_valid && s_ready && s_last) |-> (s_bytes != 4'd0 && s_bytes <= 4'd8));
endmodule

// File: tb/tb_shake_msg_packer.sv
// Scoreboard bench for shake_msg_packer: messages are modelled as byte streams, blocks checked on ack.
module tb_shake_msg_packer;
    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   s_data;
    logic [3:0]    s_bytes;
    logic          s_last;
    logic          s_mode;
    logic          s_valid;
    logic          s_ready;
    logic [1023:0] o_din;
    logic [6:0]    o_byte_len;
    logic          o_last;
    logic          o_mode;
    logic          o_valid;
    logic          i_ack;
    logic          busy;

    typedef struct {
        logic [1023:0] din;
        logic [6:0]    len;
        logic          last;
        logic          mode;
    } blk_t;

    blk_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   ack_delay = 1;

    shake_msg_packer dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_bytes    (s_bytes),
        .s_last     (s_last),
        .s_mode     (s_mode),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .o_din      (o_din),
        .o_byte_len (o_byte_len),
        .o_last     (o_last),
        .o_mode     (o_mode),
        .o_valid    (o_valid),
        .i_ack      (i_ack),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Sponge model: acks each block after ack_delay cycles and checks it against the scoreboard.
    initial begin
        int            vcnt;
        logic [1023:0] snap_din;
        logic [6:0]    snap_len, held_len;
        logic          snap_last, held_last, unstable;
        blk_t          e;
        i_ack = 1'b0;
        vcnt = 0;
        held_len = '0;
        held_last = 1'b0;
        unstable = 1'b0;
        forever begin
            @(negedge clk);
            if (i_ack) begin
                i_ack = 1'b0;
                vcnt = 0;
                n_chk++;
                if (o_valid !== 1'b0 || o_last !== held_last || o_byte_len !== held_len) begin
                    n_fail++;
                    $display("FAIL ack_hold: o_valid=%b o_last=%b o_byte_len=%0d, required 0/%b/%0d",
                             o_valid, o_last, o_byte_len, held_last, held_len);
                end
            end else if (rst !== 1'b1) begin
                vcnt = 0;
            end else if (o_valid === 1'b1) begin
                if (vcnt == 0) begin
                    snap_din = o_din;
                    snap_len = o_byte_len;
                    snap_last = o_last;
                    unstable = 1'b0;
                end else if (o_din !== snap_din || o_byte_len !== snap_len || o_last !== snap_last) begin
                    unstable = 1'b1;
                end
                if (vcnt >= ack_delay) begin
                    i_ack = 1'b1;
                    held_last = o_last;
                    held_len = o_byte_len;
                    n_chk++;
                    if (unstable) begin
                        n_fail++;
                        $display("FAIL blk_stable: outputs changed while waiting %0d cycles for ack", vcnt);
                    end
                    n_chk++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_block: got block o_din[63:0]=%h, required no block", o_din[63:0]);
                    end else begin
                        e = sb.pop_front();
                        if (o_din !== e.din) begin
                            n_fail++;
                            $display("FAIL blk_din: got low256=%h, required low256=%h", o_din[255:0], e.din[255:0]);
                        end
                        n_chk++;
                        if (o_byte_len !== e.len) begin
                            n_fail++;
                            $display("FAIL blk_len: got %0d, required %0d", o_byte_len, e.len);
                        end
                        n_chk++;
                        if (o_last !== e.last) begin
                            n_fail++;
                            $display("FAIL blk_last: got %b, required %b", o_last, e.last);
                        end
                        n_chk++;
                        if (o_mode !== e.mode) begin
                            n_fail++;
                            $display("FAIL blk_mode: got %b, required %b", o_mode, e.mode);
                        end
                    end
                end
                vcnt++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time, required completion");
        $fatal(1, "watchdog");
    end

    task automatic put(input logic [63:0] d, input logic [3:0] nb, input logic lst,
                       input logic md, output int waited);
        int g = 0;
        s_data = d;
        s_bytes = nb;
        s_last = lst;
        s_mode = md;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) begin
            n_chk++;
            n_fail++;
            $display("FAIL put_timeout: s_ready=%b after %0d cycles, required 1", s_ready, g);
        end
        @(negedge clk);
        s_valid = 1'b0;
        waited = g;
    endtask

    // Reference model: message byte i comes from word i/8; blocks are consecutive 128-byte slices.
    task automatic send_msg(input logic [63:0] w[$], input int total, input logic mode, output int wait0);
        blk_t e;
        int   nfull = total / 128;
        int   nw = (total + 7) / 8;
        int   wt;
        for (int k = 0; k <= nfull; k++) begin
            e.din = '0;
            for (int j = 0; j < 128; j++) begin
                int i = 128 * k + j;
                if (i < total) begin
`ifdef SHAKE_PACK_BSWAP_EN
                    e.din[8*j +: 8] = w[i/8][8*(7-(i%8)) +: 8];
`else
                    e.din[8*j +: 8] = w[i/8][8*(i%8) +: 8];
`endif
                end
            end
            e.last = (k == nfull);
            e.len = (k == nfull) ? 7'(total % 128) : 7'd0;
            e.mode = mode;
            sb.push_back(e);
        end
        wait0 = 0;
        for (int i = 0; i < nw; i++) begin
            if (i == nw - 1)
                put(w[i], 4'(total - 8 * (nw - 1)), 1'b1, (i == 0) ? mode : 1'($urandom), wt);
            else
                put(w[i], 4'($urandom_range(0, 15)), 1'b0, (i == 0) ? mode : 1'($urandom), wt);
            if (i == 0)
                wait0 = wt;
        end
    endtask

    task automatic rand_words(input int total, output logic [63:0] w[$]);
        w = {};
        for (int i = 0; i < (total + 7) / 8; i++)
            w.push_back({$urandom, $urandom});
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        while ((sb.size() != 0 || o_valid !== 1'b0) && g < 5000) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        n_chk++;
        if (g >= 5000) begin
            n_fail++;
            $display("FAIL %s_drain: %0d blocks still expected after %0d cycles, required 0", name, sb.size(), g);
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy_idle: busy=%b, required 0", name, busy);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_chk++;
        if (o_valid !== 1'b0 || o_last !== 1'b0 || o_byte_len !== 7'd0 || o_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ctrl: valid=%b last=%b len=%0d mode=%b, required all 0",
                     name, o_valid, o_last, o_byte_len, o_mode);
        end
        n_chk++;
        if (o_din !== '0) begin
            n_fail++;
            $display("FAIL %s_din: got low256=%h, required 0", name, o_din[255:0]);
        end
        n_chk++;
        if (busy !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy_ready: busy=%b s_ready=%b, required 0/1", name, busy, s_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        s_bytes = '0;
        s_last = 1'b0;
        s_mode = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abc();
        logic [63:0] w[$];
        int          wt;
        ack_delay = 2;
        w = {64'hC3D4E5F6A7636261};
        send_msg(w, 3, 1'b1, wt);
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abc_busy: busy=%b while block pending, required 1", busy);
        end
        wait_idle("abc");
    endtask

    task automatic test_two_blocks();
        logic [63:0] w[$];
        int          wt;
        ack_delay = 1;
        rand_words(133, w);
        send_msg(w, 133, 1'b0, wt);
        wait_idle("two_blocks");
    endtask

    task automatic test_exact_128();
        logic [63:0] w[$];
        int          wt;
        ack_delay = 0;
        rand_words(128, w);
        send_msg(w, 128, 1'b1, wt);
        wait_idle("exact_128");
    endtask

    task automatic test_ack_delay();
        logic [63:0] w[$];
        int          wt;
        ack_delay = 20;
        rand_words(5, w);
        send_msg(w, 5, 1'b1, wt);
        rand_words(4, w);
        send_msg(w, 4, 1'b0, wt);
        n_chk++;
        if (wt < 20) begin
            n_fail++;
            $display("FAIL ack_delay_stall: word consumed after %0d cycles, required >= 20", wt);
        end
        wait_idle("ack_delay");
        ack_delay = 1;
    endtask

    task automatic test_reset_mid();
        logic [63:0] w[$];
        int          wt;
        for (int i = 0; i < 7; i++)
            put({$urandom, $urandom}, 4'd8, 1'b0, 1'b1, wt);
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_busy: busy=%b after 7 words, required 1", busy);
        end
        rst = 1'b0;
        #1;
        check_idle_outputs("reset_mid");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        w = {64'h1122334455667788};
        send_msg(w, 3, 1'b1, wt);
        wait_idle("reset_mid_next");
    endtask

    task automatic test_bswap_word();
        logic [63:0] w[$];
        int          wt;
        w = {64'h0102030405060708};
        send_msg(w, 2, 1'b0, wt);
        wait_idle("bswap_word");
    endtask

    task automatic test_back_to_back();
        logic [63:0] w[$];
        int          lens[6];
        int          wt;
        lens = '{1, 8, 127, 129, 256, 0};
        lens[5] = $urandom_range(1, 300);
        for (int m = 0; m < 6; m++) begin
            ack_delay = $urandom_range(0, 3);
            rand_words(lens[m], w);
            send_msg(w, lens[m], 1'($urandom), wt);
        end
        wait_idle("back_to_back");
    endtask

    initial begin
        test_reset();
        test_abc();
        test_two_blocks();
        test_exact_128();
        test_ack_delay();
        test_reset_mid();
        test_bswap_word();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
